fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, drives the

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Bundle between the fetch stage and its surroundings: instruction memory,
// hazard/redirect inputs and the IF/ID register outputs toward decode.
interface fetch_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            pc_src;
    logic [PC_W-1:0] pc_target;
    logic [31:0]     if_id_inst;
    logic [PC_W-1:0] if_id_pc4;
    logic            if_id_valid;
    logic            pipe_stall;
    logic            halted;

    modport master (
        output imem_addr, if_id_inst, if_id_pc4, if_id_valid, pipe_stall, halted,
        input  imem_rdata, stall, pc_src, pc_target
    );

    modport slave (
        input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, pipe_stall, halted,
        output imem_rdata, stall, pc_src, pc_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: PC sequencing, load-use stall,
// branch/jump redirect with one-slot flush, and HLT freeze.
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0000
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    fetch_if.master  bus
);

    typedef enum logic {S_RUN, S_HALTED} state_t;

    localparam logic [5:0] HLT_OP = 6'b111111;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_inst_p1;
    logic [PC_W-1:0] r_pc4_p1;
    logic            r_vld_p1;

    state_t          w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [31:0]     w_inst_nxt;
    logic [PC_W-1:0] w_pc4_nxt;
    logic            w_vld_nxt;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_target;

    assign w_pc_plus4 = r_pc + PC_W'(4);
    assign w_target   = bus.pc_target & ~PC_W'(3);

    // Priority: redirect beats stall, stall beats HLT detection and normal fetch
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst_p1;
        w_pc4_nxt   = r_pc4_p1;
        w_vld_nxt   = r_vld_p1;
        if (bus.pc_src) begin
            w_pc_nxt    = w_target;
            w_inst_nxt  = NOP_INST;
            w_pc4_nxt   = '0;
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_RUN;
        end else if (!bus.stall) begin
            case (r_state)
                S_RUN: begin
                    w_inst_nxt = bus.imem_rdata;
                    w_pc4_nxt  = w_pc_plus4;
                    w_vld_nxt  = 1'b1;
                    if (bus.imem_rdata[31:26] == HLT_OP)
                        w_state_nxt = S_HALTED;
                    else
                        w_pc_nxt = w_pc_plus4;
                end
                S_HALTED: begin
                    w_inst_nxt = NOP_INST;
                    w_pc4_nxt  = '0;
                    w_vld_nxt  = 1'b0;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // IF -> ID boundary
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_inst_p1 <= NOP_INST;
            r_pc4_p1  <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst_p1 <= w_inst_nxt;
            r_pc4_p1  <= w_pc4_nxt;
            r_vld_p1  <= w_vld_nxt;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.if_id_inst  = r_inst_p1;
    assign bus.if_id_pc4   = r_pc4_p1;
    assign bus.if_id_valid = r_vld_p1;
    assign bus.halted      = (r_state == S_HALTED);
    assign bus.pipe_stall  = bus.stall | ~r_vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for async reset,
// and randomized redirect/stall traffic against a behavioural model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;

    fetch_if #(.PC_W(32)) bus ();

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: a few fixed words, otherwise an address-derived
    // non-HLT word so every fetch is distinguishable.
    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0000_0000: memword = 32'h2008_0001;
            32'h0000_0004: memword = 32'h2009_0002;
            32'h0000_0020: memword = 32'hFC00_0000;
            default:       memword = {6'b000100, a[27:2]};
        endcase
    endfunction

    assign bus.imem_rdata = memword(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                           input logic [31:0] pc4, input logic vld, input logic hlt, input logic ps);
        chk({tag, ".addr"},  bus.imem_addr,        addr);
        chk({tag, ".inst"},  bus.if_id_inst,       inst);
        chk({tag, ".pc4"},   bus.if_id_pc4,        pc4);
        chk({tag, ".valid"}, 32'(bus.if_id_valid), 32'(vld));
        chk({tag, ".halt"},  32'(bus.halted),      32'(hlt));
        chk({tag, ".pstl"},  32'(bus.pipe_stall),  32'(ps));
    endtask

    task automatic step(input logic s, input logic p, input logic [31:0] t);
        bus.stall     = s;
        bus.pc_src    = p;
        bus.pc_target = t;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        pc_src;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_vld;
        logic        e_hlt;
        logic        e_ps;
    } vec_t;

    vec_t vecs[18];

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_vld, m_hlt;

    task automatic model_step(input logic s, input logic p, input logic [31:0] t);
        logic [31:0] w;
        if (p) begin
            m_pc = {t[31:2], 2'b00}; m_inst = 0; m_pc4 = 0; m_vld = 0; m_hlt = 0;
        end else if (s) begin
            // everything frozen
        end else if (!m_hlt) begin
            w = memword(m_pc);
            m_inst = w; m_pc4 = m_pc + 32'd4; m_vld = 1;
            if (w[31:26] == 6'b111111) m_hlt = 1;
            else m_pc = m_pc + 32'd4;
        end else begin
            m_inst = 0; m_pc4 = 0; m_vld = 0;
        end
    endtask

    initial begin
        vecs[0]  = '{0,0,0,          32'h4,        32'h2008_0001, 32'h4,  1,0,0};
        vecs[1]  = '{0,0,0,          32'h8,        32'h2009_0002, 32'h8,  1,0,0};
        vecs[2]  = '{1,0,0,          32'h8,        32'h2009_0002, 32'h8,  1,0,1};
        vecs[3]  = '{1,0,0,          32'h8,        32'h2009_0002, 32'h8,  1,0,1};
        vecs[4]  = '{0,0,0,          32'hC,        32'h1000_0002, 32'hC,  1,0,0};
        vecs[5]  = '{0,0,0,          32'h10,       32'h1000_0003, 32'h10, 1,0,0};
        vecs[6]  = '{0,1,32'h43,     32'h40,       32'h0,         32'h0,  0,0,1};
        vecs[7]  = '{0,0,0,          32'h44,       32'h1000_0010, 32'h44, 1,0,0};
        vecs[8]  = '{1,1,32'h80,     32'h80,       32'h0,         32'h0,  0,0,1};
        vecs[9]  = '{0,1,32'h20,     32'h20,       32'h0,         32'h0,  0,0,1};
        vecs[10] = '{0,0,0,          32'h20,       32'hFC00_0000, 32'h24, 1,1,0};
        vecs[11] = '{0,0,0,          32'h20,       32'h0,         32'h0,  0,1,1};
        vecs[12] = '{0,0,0,          32'h20,       32'h0,         32'h0,  0,1,1};
        vecs[13] = '{0,1,32'h100,    32'h100,      32'h0,         32'h0,  0,0,1};
        vecs[14] = '{0,0,0,          32'h104,      32'h1000_0040, 32'h104,1,0,0};
        vecs[15] = '{0,1,32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,     32'h0,  0,0,1};
        vecs[16] = '{0,0,0,          32'h0,        32'h13FF_FFFF, 32'h0,  1,0,0};
        vecs[17] = '{0,0,0,          32'h4,        32'h2008_0001, 32'h4,  1,0,0};

        bus.stall = 0; bus.pc_src = 0; bus.pc_target = 0;

        // Held in reset across edges, even with a redirect requested
        @(posedge clk); #1;
        bus.pc_src = 1; bus.pc_target = 32'h200;
        @(posedge clk); #1;
        chk_all("rst", 32'h0, 32'h0, 32'h0, 0, 0, 1);
        bus.pc_src = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].stall, vecs[i].pc_src, vecs[i].tgt);
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_inst,
                    vecs[i].e_pc4, vecs[i].e_vld, vecs[i].e_hlt, vecs[i].e_ps);
        end

        // Async reset asserted mid-stall, between clock edges
        step(0, 0, 0);
        step(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 32'h0, 32'h0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk_all("post_rst", 32'h4, 32'h2008_0001, 32'h4, 1, 0, 0);

        // Async reset while halted
        step(0, 1, 32'h20);
        step(0, 0, 0);
        chk("halt_pre", 32'(bus.halted), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst_hlt", 32'h0, 32'h0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic vs model
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_vld = 0; m_hlt = 0;
        for (int c = 0; c < 400; c++) begin
            logic s, p;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'h20 | $urandom_range(0, 3);
                1:       t = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: t = $urandom_range(0, 255);
            endcase
            step(s, p, t);
            model_step(s, p, t);
            chk_all($sformatf("rnd%0d", c), m_pc, m_inst, m_pc4, m_vld, m_hlt, s | ~m_vld);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
